// File: rtl/quad_gen.sv
// Quadrature A/B generator: emits Gray-coded step bursts at a programmable edge
// rate, with optional contact-bounce glitch trains after each edge.
module quad_gen #(
    parameter int WIDTH      = 8,
    parameter int DIV_WIDTH  = 16,
    parameter int BOUNCE_LEN = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_dir,
    input  logic [WIDTH-1:0]     cmd_steps,
    input  logic [DIV_WIDTH-1:0] cmd_half_period,
    input  logic                 cmd_bounce_en,
    output logic                 enc_a,
    output logic                 enc_b,
    output logic                 busy,
    output logic [WIDTH-1:0]     position
);

    localparam int GLITCH_LEN = 2 * BOUNCE_LEN;
    localparam int GW         = $clog2(GLITCH_LEN + 1);

    localparam logic [GW-1:0]        GLITCH_LOAD = GW'(GLITCH_LEN);
    localparam logic [GW-1:0]        GLITCH_ZERO = {GW{1'b0}};
    localparam logic [GW-1:0]        GLITCH_ONE  = {{(GW-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]     STEP_ZERO   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]     STEP_ONE    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DIV_WIDTH-1:0] TIMER_ZERO  = {DIV_WIDTH{1'b0}};
    localparam logic [DIV_WIDTH-1:0] TIMER_ONE   = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_BOUNCE = 2'd2
    } state_t;

    state_t               state_r;
    logic [1:0]           phase_r;
    logic                 dir_r;
    logic                 bounce_en_r;
    logic [WIDTH-1:0]     steps_r;
    logic [DIV_WIDTH-1:0] half_r;
    logic [DIV_WIDTH-1:0] timer_r;
    logic [GW-1:0]        glitch_cnt_r;
    logic                 glitch_on_a_r;
    logic                 enc_a_r;
    logic                 enc_b_r;
    logic                 busy_r;
    logic                 cmd_ready_r;
    logic [WIDTH-1:0]     position_r;

    logic [1:0]           cur_ab_s;
    logic [1:0]           nxt_phase_s;
    logic [1:0]           nxt_ab_s;
    logic [WIDTH-1:0]     nxt_pos_s;
    logic                 edge_s;
    logic                 last_edge_s;
    logic                 accept_s;
    logic [DIV_WIDTH-1:0] half_s;

    // Gray sequence: phase 0..3 maps to (a,b) = 00, 10, 11, 01; result is {a,b}.
    function automatic logic [1:0] phase_to_ab(input logic [1:0] ph);
        logic [1:0] ab;
        case (ph)
            2'd0:    ab = 2'b00;
            2'd1:    ab = 2'b10;
            2'd2:    ab = 2'b11;
            2'd3:    ab = 2'b01;
            default: ab = 2'b00;
        endcase
        return ab;
    endfunction

    // Edge arithmetic and handshake decode feeding the state register.
    always_comb begin
        cur_ab_s    = phase_to_ab(phase_r);
        nxt_phase_s = dir_r ? (phase_r + 2'd1) : (phase_r - 2'd1);
        nxt_ab_s    = phase_to_ab(nxt_phase_s);
        nxt_pos_s   = dir_r ? (position_r + STEP_ONE) : (position_r - STEP_ONE);
        // Timer is never zero in HOLD; <= guards against a corrupted zero stalling forever.
        edge_s      = (state_r == ST_HOLD) && (timer_r <= TIMER_ONE);
        last_edge_s = edge_s && (steps_r == STEP_ONE);
        accept_s    = cmd_valid && cmd_ready_r && (state_r == ST_IDLE);
        if (cmd_half_period == TIMER_ZERO) begin
            half_s = TIMER_ONE;
        end else begin
            half_s = cmd_half_period;
        end
    end

    // Command FSM with registered A/B, position and handshake outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            phase_r       <= 2'd0;
            dir_r         <= 1'b0;
            bounce_en_r   <= 1'b0;
            steps_r       <= STEP_ZERO;
            half_r        <= TIMER_ONE;
            timer_r       <= TIMER_ZERO;
            glitch_cnt_r  <= GLITCH_ZERO;
            glitch_on_a_r <= 1'b0;
            enc_a_r       <= 1'b0;
            enc_b_r       <= 1'b0;
            busy_r        <= 1'b0;
            cmd_ready_r   <= 1'b0;
            position_r    <= STEP_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        dir_r       <= cmd_dir;
                        bounce_en_r <= cmd_bounce_en;
                        steps_r     <= cmd_steps;
                        half_r      <= half_s;
                        timer_r     <= half_s;
                        busy_r      <= 1'b1;
                        cmd_ready_r <= 1'b0;
                        if (cmd_steps == STEP_ZERO) begin
                            glitch_cnt_r <= GLITCH_ZERO;
                            state_r      <= ST_BOUNCE;
                        end else begin
                            state_r      <= ST_HOLD;
                        end
                    end else begin
                        busy_r      <= 1'b0;
                        cmd_ready_r <= 1'b1;
                    end
                end

                ST_HOLD: begin
                    if (edge_s) begin
                        phase_r       <= nxt_phase_s;
                        enc_a_r       <= nxt_ab_s[1];
                        enc_b_r       <= nxt_ab_s[0];
                        position_r    <= nxt_pos_s;
                        steps_r       <= steps_r - STEP_ONE;
                        timer_r       <= half_r;
                        glitch_on_a_r <= cur_ab_s[1] ^ nxt_ab_s[1];
                        // A new edge always restarts the train, pre-empting any unfinished one.
                        glitch_cnt_r  <= bounce_en_r ? GLITCH_LOAD : GLITCH_ZERO;
                        if (last_edge_s && bounce_en_r) begin
                            state_r <= ST_BOUNCE;
                        end else if (last_edge_s) begin
                            state_r     <= ST_IDLE;
                            busy_r      <= 1'b0;
                            cmd_ready_r <= 1'b1;
                        end else begin
                            state_r <= ST_HOLD;
                        end
                    end else begin
                        timer_r <= timer_r - TIMER_ONE;
                        if (glitch_cnt_r != GLITCH_ZERO) begin
                            glitch_cnt_r <= glitch_cnt_r - GLITCH_ONE;
                            if (glitch_on_a_r) begin
                                enc_a_r <= ~enc_a_r;
                            end else begin
                                enc_b_r <= ~enc_b_r;
                            end
                        end else begin
                            glitch_cnt_r <= GLITCH_ZERO;
                        end
                    end
                end

                ST_BOUNCE: begin
                    if (glitch_cnt_r == GLITCH_ZERO) begin
                        state_r     <= ST_IDLE;
                        busy_r      <= 1'b0;
                        cmd_ready_r <= 1'b1;
                    end else begin
                        glitch_cnt_r <= glitch_cnt_r - GLITCH_ONE;
                        if (glitch_on_a_r) begin
                            enc_a_r <= ~enc_a_r;
                        end else begin
                            enc_b_r <= ~enc_b_r;
                        end
                        // Train length is even, so the final toggle lands on the settled value.
                        if (glitch_cnt_r == GLITCH_ONE) begin
                            state_r     <= ST_IDLE;
                            busy_r      <= 1'b0;
                            cmd_ready_r <= 1'b1;
                        end else begin
                            state_r <= ST_BOUNCE;
                        end
                    end
                end

                default: begin
                    state_r     <= ST_IDLE;
                    busy_r      <= 1'b0;
                    cmd_ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_r;
    assign busy      = busy_r;
    assign enc_a     = enc_a_r;
    assign enc_b     = enc_b_r;
    assign position  = position_r;

endmodule

// File: tb/tb_quad_gen.sv
// Self-checking bench for quad_gen: directed corner cases plus random commands,
// compared cycle by cycle against a timeline model built from the command.
module tb_quad_gen;

    localparam int WIDTH      = 8;
    localparam int DIV_WIDTH  = 16;
    localparam int BOUNCE_LEN = 2;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 cmd_valid = 1'b0;
    logic                 cmd_ready;
    logic                 cmd_dir = 1'b0;
    logic [WIDTH-1:0]     cmd_steps = '0;
    logic [DIV_WIDTH-1:0] cmd_half_period = '0;
    logic                 cmd_bounce_en = 1'b0;
    logic                 enc_a;
    logic                 enc_b;
    logic                 busy;
    logic [WIDTH-1:0]     position;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state persisting between commands.
    int         m_phase = 0;
    logic [7:0] m_pos   = 8'd0;

    quad_gen #(
        .WIDTH(WIDTH),
        .DIV_WIDTH(DIV_WIDTH),
        .BOUNCE_LEN(BOUNCE_LEN)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_dir(cmd_dir),
        .cmd_steps(cmd_steps),
        .cmd_half_period(cmd_half_period),
        .cmd_bounce_en(cmd_bounce_en),
        .enc_a(enc_a),
        .enc_b(enc_b),
        .busy(busy),
        .position(position)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] ab_of(input int p);
        logic [1:0] tab [4];
        tab[0] = 2'b00; tab[1] = 2'b10; tab[2] = 2'b11; tab[3] = 2'b01;
        return tab[p & 3];
    endfunction

    // Issue one command and compare every cycle until it has fully completed.
    task automatic run_cmd(input bit dir, input int steps, input int hp, input bit ben,
                           input bit hold_valid);
        int h;
        int endt;
        int d;
        int k;
        int off;
        logic [1:0] ab;
        logic [7:0] pos;
        h    = (hp == 0) ? 1 : hp;
        endt = (steps == 0) ? 1 : steps * h + (ben ? 2 * BOUNCE_LEN : 0);
        d    = dir ? 1 : -1;
        @(negedge clk);
        cmd_valid       = 1'b1;
        cmd_dir         = dir;
        cmd_steps       = 8'(steps);
        cmd_half_period = 16'(hp);
        cmd_bounce_en   = ben;
        @(posedge clk);
        #1;
        for (int t = 0; t <= endt; t++) begin
            if (t > 0) begin
                @(posedge clk);
                #1;
            end
            if (hold_valid) begin
                cmd_dir         = 1'($urandom);
                cmd_steps       = 8'($urandom_range(0, 9));
                cmd_half_period = 16'($urandom_range(0, 4));
                cmd_bounce_en   = 1'($urandom);
            end else begin
                cmd_valid = 1'b0;
            end
            k = t / h;
            if (k > steps) k = steps;
            off = t - k * h;
            ab  = ab_of(m_phase + d * k);
            // Odd cycles of a glitch train show the line's pre-edge level.
            if (ben && k >= 1 && off >= 1 && off <= 2 * BOUNCE_LEN && (off % 2) == 1)
                ab = ab_of(m_phase + d * (k - 1));
            pos = 8'(int'(m_pos) + d * k);
            check_eq("enc_a", {31'd0, enc_a}, {31'd0, ab[1]});
            check_eq("enc_b", {31'd0, enc_b}, {31'd0, ab[0]});
            check_eq("position", {24'd0, position}, {24'd0, pos});
            check_eq("busy", {31'd0, busy}, (t < endt) ? 32'd1 : 32'd0);
            check_eq("cmd_ready", {31'd0, cmd_ready}, (t < endt) ? 32'd0 : 32'd1);
        end
        cmd_valid = 1'b0;
        m_phase = (m_phase + d * steps) & 3;
        m_pos   = 8'(int'(m_pos) + d * steps);
    endtask

    task automatic check_cleared(input string tag);
        check_eq({tag, "_a"}, {31'd0, enc_a}, 32'd0);
        check_eq({tag, "_b"}, {31'd0, enc_b}, 32'd0);
        check_eq({tag, "_pos"}, {24'd0, position}, 32'd0);
        check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check_eq({tag, "_ready"}, {31'd0, cmd_ready}, 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_cleared("rst_hold");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_eq("ready_after_rst", {31'd0, cmd_ready}, 32'd1);
        check_eq("busy_after_rst", {31'd0, busy}, 32'd0);

        run_cmd(1'b0, 2, 0, 1'b0, 1'b0);   // reverse wrap 0 -> 255 -> 254
        run_cmd(1'b1, 4, 3, 1'b0, 1'b0);   // forward burst
        run_cmd(1'b1, 1, 10, 1'b1, 1'b0);  // single edge with bounce
        run_cmd(1'b1, 3, 2, 1'b1, 1'b0);   // trains pre-empted by next edge
        run_cmd(1'b0, 0, 5, 1'b1, 1'b0);   // zero-length command
        run_cmd(1'b1, 5, 2, 1'b0, 1'b1);   // valid held high while busy
        run_cmd(1'b1, 3, 1, 1'b1, 1'b0);   // edge every cycle with bounce on

        for (int i = 0; i < 40; i++) begin
            run_cmd(1'($urandom), $urandom_range(0, 7), $urandom_range(0, 5),
                    1'($urandom), 1'($urandom));
        end

        // Reset in the middle of a 5-edge command, after its second edge.
        @(negedge clk);
        cmd_valid       = 1'b1;
        cmd_dir         = 1'b1;
        cmd_steps       = 8'd5;
        cmd_half_period = 16'd3;
        cmd_bounce_en   = 1'b0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check_eq("mid_pos", {24'd0, position}, {24'd0, 8'(int'(m_pos) + 2)});
        check_eq("mid_busy", {31'd0, busy}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_cleared("async_rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        m_phase = 0;
        m_pos   = 8'd0;
        @(posedge clk);
        #1;
        check_eq("ready_after_rst2", {31'd0, cmd_ready}, 32'd1);
        run_cmd(1'b1, 1, 1, 1'b0, 1'b0);
        check_eq("post_rst_ab", {30'd0, enc_a, enc_b}, 32'd2);
        check_eq("post_rst_pos", {24'd0, position}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
